// File: rtl/bcd_decrementor_timer.sv
// bcd_decrementor_timer: loadable packed-BCD countdown timer with tick prescaler and zero flag
module bcd_decrementor_timer #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 1,
  parameter int WRAP     = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                start,
  input  logic                stop,
  input  logic                tick_en,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DN} state_t;

  state_t         st, st_n;
  logic [PW-1:0]  pre, pre_n;
  logic [W-1:0]   bcd_n, dec;
  logic           err_n, done_n, busy_n, pulse, valid;

  // Borrow ripples through zero digits (which become 9) and stops at the first nonzero digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        r[4*i+:4] = (v[4*i+:4] == 4'd0) ? 4'd9 : v[4*i+:4] - 4'd1;
        b = (v[4*i+:4] == 4'd0);
      end
    end
    return r;
  endfunction

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i+:4] > 4'd9) valid = 1'b0;
  end

  assign dec = bcd_dec(bcd_out);

  always_comb begin
    st_n  = st;
    bcd_n = bcd_out;
    pre_n = pre;
    err_n = err;
    pulse = 1'b0;
    if (load) begin
      st_n  = IDLE;
      pre_n = '0;
      err_n = !valid;
      bcd_n = valid ? bcd_in : bcd_out;
    end else if (stop && st == RUN) begin
      st_n  = IDLE;
      pre_n = '0;
    end else if (start && st == IDLE) begin
      if (bcd_out != '0) begin
        st_n  = RUN;
        pre_n = '0;
      end else if (WRAP != 0) begin
        pulse = 1'b1;
      end else begin
        st_n = DN;
      end
    end else if (tick_en && st == RUN) begin
      if (pre == PW'(TICK_DIV - 1)) begin
        pre_n = '0;
        bcd_n = dec;
        if (dec == '0) begin
          if (WRAP != 0) pulse = 1'b1;
          else st_n = DN;
        end
      end else begin
        pre_n = pre + 1'b1;
      end
    end
    done_n = (WRAP != 0) ? pulse : (st_n == DN);
    busy_n = (st_n == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= IDLE;
      pre     <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      st      <= st_n;
      pre     <= pre_n;
      bcd_out <= bcd_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_decrementor_timer.sv
// tb_bcd_decrementor_timer: random and directed checks of two timer configurations against a decimal-integer model
module tb_bcd_decrementor_timer;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  typedef struct packed {
    int   val;
    int   st;
    int   pre;
    logic done;
    logic err;
  } m_t;

  logic        clk = 1'b0, reset_n = 1'b1;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, tick_en = 1'b0;
  logic [11:0] bcd_in = '0;
  logic [11:0] bcd0, bcd1;
  logic        busy0, busy1, done0, done1, err0, err1;
  int          checks = 0, errors = 0;
  m_t          m0 = '0, m1 = '0;

  always #5 clk = ~clk;

  bcd_decrementor_timer #(.DIGITS(3), .TICK_DIV(1), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in), .start(start),
    .stop(stop), .tick_en(tick_en), .bcd_out(bcd0), .busy(busy0), .done(done0), .err(err0));

  bcd_decrementor_timer #(.DIGITS(3), .TICK_DIV(4), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in), .start(start),
    .stop(stop), .tick_en(tick_en), .bcd_out(bcd1), .busy(busy1), .done(done1), .err(err1));

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic m_t step(input m_t m, input bit wrap, input int div);
    m_t n;
    bit pulse, ok;
    int v;
    n = m;
    pulse = 0;
    ok = 1;
    v = 0;
    for (int i = 2; i >= 0; i--) begin
      if (bcd_in[4*i+:4] > 4'd9) ok = 0;
      v = v * 10 + int'(bcd_in[4*i+:4]);
    end
    if (load) begin
      n.st = M_IDLE;
      n.pre = 0;
      n.err = !ok;
      if (ok) n.val = v;
    end else if (stop && m.st == M_RUN) begin
      n.st = M_IDLE;
      n.pre = 0;
    end else if (start && m.st == M_IDLE) begin
      if (m.val != 0) begin
        n.st = M_RUN;
        n.pre = 0;
      end else if (wrap) pulse = 1;
      else n.st = M_DONE;
    end else if (tick_en && m.st == M_RUN) begin
      if (m.pre == div - 1) begin
        n.pre = 0;
        n.val = (m.val == 0) ? 999 : m.val - 1;
        if (n.val == 0) begin
          if (wrap) pulse = 1;
          else n.st = M_DONE;
        end
      end else n.pre = m.pre + 1;
    end
    n.done = wrap ? pulse : (n.st == M_DONE);
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, 1'b0, 1);
      m1 <= step(m1, 1'b1, 4);
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model bcd0", bcd0, to_bcd(m0.val));
    chk("model busy0", 12'(busy0), 12'(m0.st == M_RUN));
    chk("model done0", 12'(done0), 12'(m0.done));
    chk("model err0", 12'(err0), 12'(m0.err));
    chk("model bcd1", bcd1, to_bcd(m1.val));
    chk("model busy1", 12'(busy1), 12'(m1.st == M_RUN));
    chk("model done1", 12'(done1), 12'(m1.done));
    chk("model err1", 12'(err1), 12'(m1.err));
  end

  task automatic drive(input logic l, input logic [11:0] b, input logic s, input logic p, input logic t);
    @(negedge clk);
    load = l;
    bcd_in = b;
    start = s;
    stop = p;
    tick_en = t;
  endtask

  task automatic dec_case(input logic [11:0] v, input logic [11:0] exp);
    drive(1, v, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    chk("borrow", bcd0, exp);
  endtask

  initial begin
    logic [11:0] rb;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("reset bcd0", bcd0, 12'h000);
    chk("reset err0", 12'(err0), 12'h0);
    dec_case(12'h125, 12'h124);
    dec_case(12'h130, 12'h129);
    dec_case(12'h100, 12'h099);
    dec_case(12'h010, 12'h009);
    drive(1, 12'h002, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("term first", bcd0, 12'h001);
    drive(0, 0, 0, 0, 1);
    chk("term zero", bcd0, 12'h000);
    chk("term done", 12'(done0), 12'h1);
    chk("term busy", 12'(busy0), 12'h0);
    drive(0, 0, 1, 0, 0);
    chk("term third tick", bcd0, 12'h000);
    drive(0, 0, 0, 0, 0);
    chk("term start ign", 12'(done0), 12'h1);
    drive(1, 12'h001, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 1);
    chk("prescale 3", bcd1, 12'h001);
    drive(0, 0, 0, 0, 0);
    chk("wrap zero", bcd1, 12'h000);
    chk("wrap pulse", 12'(done1), 12'h1);
    drive(0, 0, 0, 0, 0);
    chk("wrap pulse end", 12'(done1), 12'h0);
    chk("wrap busy", 12'(busy1), 12'h1);
    repeat (4) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk("wrap 999", bcd1, 12'h999);
    drive(1, 12'h050, 0, 0, 0);
    drive(1, 12'h1A3, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("invalid err", 12'(err0), 12'h1);
    chk("invalid hold", bcd0, 12'h050);
    drive(1, 12'h050, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("load>start bcd", bcd0, 12'h050);
    chk("load>start err", 12'(err0), 12'h0);
    chk("load>start busy", 12'(busy0), 12'h0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    chk("stop>tick bcd", bcd0, 12'h050);
    chk("stop>tick busy", 12'(busy0), 12'h0);
    drive(1, 12'h000, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("zero start done", 12'(done0), 12'h1);
    chk("zero start busy", 12'(busy0), 12'h0);
    drive(1, 12'h047, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre-reset busy", 12'(busy0), 12'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async bcd0", bcd0, 12'h000);
    chk("async busy0", 12'(busy0), 12'h0);
    chk("async done0", 12'(done0), 12'h0);
    chk("async err0", 12'(err0), 12'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++)
        rb[4*i+:4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      drive($urandom_range(0, 19) == 0, rb, $urandom_range(0, 9) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
